// File: rtl/exp_norm_pkg.sv
// exp_norm_pkg: shared state encoding and width/lane helpers for the exponent normalizer
package exp_norm_pkg;
  typedef enum logic {COLLECT = 1'b0, DRAIN = 1'b1} state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction
endpackage

// File: rtl/exp_max_tree.sv
// exp_max_tree: combinational unsigned max-reduction tree over LANES packed exponents
module exp_max_tree
  import exp_norm_pkg::*;
#(
  parameter int EXP_WIDTH = 3,
  parameter int LANES = 4
) (
  input  logic [EXP_WIDTH*LANES-1:0] exp_i,
  output logic [EXP_WIDTH-1:0]       max_o
);
  localparam int P = 1 << clog2(LANES);
  // Heap-ordered tree: leaves at [P..2P-1], padding leaves are 0 which never wins an unsigned max.
  logic [EXP_WIDTH-1:0] node [2*P];
  always_comb begin
    node = '{default: '0};
    for (int i = 0; i < LANES; i++) node[P+i] = exp_i[lane_lo(i, EXP_WIDTH) +: EXP_WIDTH];
    for (int k = P - 1; k >= 1; k--) node[k] = (node[2*k] > node[2*k+1]) ? node[2*k] : node[2*k+1];
  end
  assign max_o = node[1];
endmodule

// File: rtl/exp_block_normalizer.sv
// exp_block_normalizer: buffers a group of exponent beats, then replays them with
// clamped right-shift offsets relative to the shared group maximum.
module exp_block_normalizer
  import exp_norm_pkg::*;
#(
  parameter int EXP_WIDTH = 3,
  parameter int LANES = 4,
  parameter int DEPTH = 4,
  parameter int MAX_SHIFT = 2**EXP_WIDTH - 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [EXP_WIDTH*LANES-1:0] in_exp,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_WIDTH*LANES-1:0] out_exp_offset,
  output logic [LANES-1:0]           out_flush,
  output logic [EXP_WIDTH-1:0]       out_max_exp,
  output logic                       out_last
);
  localparam int EW = EXP_WIDTH;
  localparam int CW = clog2(DEPTH + 1);
  localparam int RW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [EW-1:0] run_max_q, run_max_d, grp_max_q, grp_max_d, beat_max, new_max;
  logic [RW-1:0] rd_q, rd_d, last_q, last_d;
  logic [EW*LANES-1:0] buf_q [2**RW];
  logic [EW*LANES-1:0] cur;
  logic drain, acc, close;
  exp_max_tree #(.EXP_WIDTH(EW), .LANES(LANES)) u_max (.exp_i(in_exp), .max_o(beat_max));
  assign drain = state_q == DRAIN;
  assign in_ready = !drain;
  assign out_valid = drain;
  assign acc = in_valid && !drain;
  assign new_max = (count_q == '0 || beat_max > run_max_q) ? beat_max : run_max_q;
  assign close = acc && (in_last || count_q == CW'(DEPTH - 1));
  assign cur = buf_q[rd_q];
  assign out_last = drain && rd_q == last_q;
  assign out_max_exp = drain ? grp_max_q : '0;
  always_comb begin
    state_d = state_q;
    count_d = acc ? count_q + 1'b1 : count_q;
    run_max_d = acc ? new_max : run_max_q;
    grp_max_d = close ? new_max : grp_max_q;
    last_d = close ? count_q[RW-1:0] : last_q;
    rd_d = close ? '0 : rd_q;
    if (close) state_d = DRAIN;
    if (drain && out_ready) begin
      rd_d = rd_q + 1'b1;
      if (out_last) begin
        state_d = COLLECT;
        count_d = '0;
        run_max_d = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      count_q <= '0;
      run_max_q <= '0;
      grp_max_q <= '0;
      rd_q <= '0;
      last_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      run_max_q <= run_max_d;
      grp_max_q <= grp_max_d;
      rd_q <= rd_d;
      last_q <= last_d;
    end
  end
  // Buffer contents are don't-care after reset; only slots below the group length are ever read.
  always_ff @(posedge clk) if (acc) buf_q[count_q[RW-1:0]] <= in_exp;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [EW-1:0] diff;
    logic clamp;
    assign diff = grp_max_q - cur[lane_lo(i, EW) +: EW];
    assign clamp = diff > EW'(MAX_SHIFT);
    assign out_exp_offset[lane_lo(i, EW) +: EW] = drain ? (clamp ? EW'(MAX_SHIFT) : diff) : '0;
    assign out_flush[i] = drain && clamp;
  end
endmodule

// File: tb/tb_exp_block_normalizer.sv
// tb_exp_block_normalizer: directed and randomized checks of the exponent normalizer
// against a group-level reference model, with MAX_SHIFT=4 and the default MAX_SHIFT=7.
module tb_exp_block_normalizer;
  localparam int EW = 3;
  localparam int L = 4;
  localparam int W = EW * L;
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [W-1:0] in_exp = '0;
  logic in_ready, out_valid, out_last, in_ready2, out_valid2, out_last2;
  logic [W-1:0] out_exp_offset, out_exp_offset2;
  logic [L-1:0] out_flush, out_flush2;
  logic [EW-1:0] out_max_exp, out_max_exp2;
  int tests = 0, fails = 0;

  exp_block_normalizer #(.EXP_WIDTH(EW), .LANES(L), .DEPTH(4), .MAX_SHIFT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_exp(in_exp),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_exp_offset(out_exp_offset), .out_flush(out_flush), .out_max_exp(out_max_exp),
    .out_last(out_last));
  exp_block_normalizer #(.EXP_WIDTH(EW), .LANES(L), .DEPTH(4)) dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_exp(in_exp),
    .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
    .out_exp_offset(out_exp_offset2), .out_flush(out_flush2), .out_max_exp(out_max_exp2),
    .out_last(out_last2));

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pk(input int a3, input int a2, input int a1, input int a0);
    return {EW'(a3), EW'(a2), EW'(a1), EW'(a0)};
  endfunction
  function automatic logic [W-1:0] ref_off(input logic [W-1:0] e, input int mx, input int ms);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < L; i++) begin
      int d;
      d = mx - int'(e[i*EW +: EW]);
      r[i*EW +: EW] = EW'((d > ms) ? ms : d);
    end
    return r;
  endfunction
  function automatic logic [L-1:0] ref_flush(input logic [W-1:0] e, input int mx, input int ms);
    logic [L-1:0] r;
    for (int i = 0; i < L; i++) r[i] = (mx - int'(e[i*EW +: EW])) > ms;
    return r;
  endfunction
  function automatic int ref_max(input logic [W-1:0] q[$]);
    int m;
    m = 0;
    foreach (q[k]) for (int i = 0; i < L; i++) if (int'(q[k][i*EW +: EW]) > m) m = int'(q[k][i*EW +: EW]);
    return m;
  endfunction

  task automatic send(input logic [W-1:0] e, input logic l);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    in_valid = 1;
    in_exp = e;
    in_last = l;
    @(posedge clk);
    #1;
    in_valid = 0;
    in_last = 0;
  endtask

  task automatic pop(input bit stall, output logic [W-1:0] o, output logic [L-1:0] f,
                     output logic [EW-1:0] m, output logic l, output logic [W-1:0] o2,
                     output logic [L-1:0] f2, output logic [EW-1:0] m2, output logic l2);
    bit got;
    got = 0;
    {o, f, m, l, o2, f2, m2, l2} = 'x;
    for (int c = 0; c < 50 && !got; c++) begin
      out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (out_valid && out_ready) begin
        {o, f, m, l} = {out_exp_offset, out_flush, out_max_exp, out_last};
        {o2, f2, m2, l2} = {out_exp_offset2, out_flush2, out_max_exp2, out_last2};
        got = 1;
      end
      @(posedge clk);
      #1;
    end
    out_ready = 0;
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL pop_timeout: no output beat within 50 cycles");
    end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({in_ready, out_valid, out_last, out_exp_offset, out_flush, out_max_exp, in_ready2, out_valid2} !==
        {1'b1, 1'b0, 1'b0, {W{1'b0}}, {L{1'b0}}, {EW{1'b0}}, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: rdy=%b vld=%b last=%b off=%h fl=%b max=%0d rdy2=%b vld2=%b", in_ready,
               out_valid, out_last, out_exp_offset, out_flush, out_max_exp, in_ready2, out_valid2);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_two_beat();
    logic [W-1:0] o, o2;
    logic [L-1:0] f, f2;
    logic [EW-1:0] m, m2;
    logic l, l2;
    send(pk(1, 5, 2, 3), 0);
    send(pk(6, 0, 4, 4), 1);
    tests++;
    if ({out_valid, in_ready} !== 2'b10) begin
      fails++;
      $display("FAIL two_beat_latency: vld=%b rdy=%b required 1 0", out_valid, in_ready);
    end
    pop(0, o, f, m, l, o2, f2, m2, l2);
    tests++;
    if ({o, f, m, l} !== {pk(4, 1, 4, 3), 4'b1000, 3'd6, 1'b0}) begin
      fails++;
      $display("FAIL two_beat_b0: off=%h fl=%b max=%0d last=%b required %h 1000 6 0", o, f, m, l, pk(4, 1, 4, 3));
    end
    pop(0, o, f, m, l, o2, f2, m2, l2);
    tests++;
    if ({o, f, m, l} !== {pk(0, 4, 2, 2), 4'b0100, 3'd6, 1'b1}) begin
      fails++;
      $display("FAIL two_beat_b1: off=%h fl=%b max=%0d last=%b required %h 0100 6 1", o, f, m, l, pk(0, 4, 2, 2));
    end
  endtask

  task automatic test_single_beat();
    logic [W-1:0] o, o2;
    logic [L-1:0] f, f2;
    logic [EW-1:0] m, m2;
    logic l, l2;
    send(pk(7, 7, 7, 7), 1);
    pop(0, o, f, m, l, o2, f2, m2, l2);
    tests++;
    if ({o, f, m, l, in_ready, out_valid} !== {{W{1'b0}}, 4'b0000, 3'd7, 1'b1, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL single_beat: off=%h fl=%b max=%0d last=%b rdy=%b vld=%b required 0 0000 7 1 1 0",
               o, f, m, l, in_ready, out_valid);
    end
  endtask

  task automatic test_forced_close();
    logic [W-1:0] q[$];
    logic [W-1:0] o, o2, e;
    logic [L-1:0] f, f2;
    logic [EW-1:0] m, m2;
    logic l, l2;
    int mx;
    for (int k = 0; k < 4; k++) begin
      q.push_back(W'($urandom));
      send(q[k], 0);
    end
    tests++;
    if ({out_valid, in_ready} !== 2'b10) begin
      fails++;
      $display("FAIL forced_close_enter: vld=%b rdy=%b required 1 0", out_valid, in_ready);
    end
    mx = ref_max(q);
    for (int k = 0; k < 4; k++) begin
      pop(0, o, f, m, l, o2, f2, m2, l2);
      tests++;
      if ({o, f, m, l} !== {ref_off(q[k], mx, 4), ref_flush(q[k], mx, 4), EW'(mx), k == 3}) begin
        fails++;
        $display("FAIL forced_close_b%0d: off=%h fl=%b max=%0d last=%b required %h %b %0d %0b", k, o, f, m, l,
                 ref_off(q[k], mx, 4), ref_flush(q[k], mx, 4), mx, k == 3);
      end
    end
    e = pk(0, 1, 0, 1);
    send(e, 1);
    pop(0, o, f, m, l, o2, f2, m2, l2);
    tests++;
    if ({o, f, m, l} !== {pk(1, 0, 1, 0), 4'b0000, 3'd1, 1'b1}) begin
      fails++;
      $display("FAIL forced_close_next: off=%h fl=%b max=%0d last=%b required %h 0000 1 1", o, f, m, l, pk(1, 0, 1, 0));
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] q[$];
    logic [W-1:0] o, o2, snap_o;
    logic [L-1:0] f, f2, snap_f;
    logic [EW-1:0] m, m2, snap_m;
    logic l, l2, snap_l;
    int mx;
    for (int k = 0; k < 3; k++) begin
      q.push_back(W'($urandom));
      send(q[k], k == 2);
    end
    mx = ref_max(q);
    pop(0, o, f, m, l, o2, f2, m2, l2);
    tests++;
    if ({o, f, m, l} !== {ref_off(q[0], mx, 4), ref_flush(q[0], mx, 4), EW'(mx), 1'b0}) begin
      fails++;
      $display("FAIL backpressure_b0: off=%h fl=%b max=%0d last=%b required %h %b %0d 0", o, f, m, l,
               ref_off(q[0], mx, 4), ref_flush(q[0], mx, 4), mx);
    end
    @(negedge clk);
    {snap_o, snap_f, snap_m, snap_l} = {out_exp_offset, out_flush, out_max_exp, out_last};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if ({out_exp_offset, out_flush, out_max_exp, out_last, out_valid, in_ready} !==
          {snap_o, snap_f, snap_m, snap_l, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL backpressure_hold%0d: off=%h fl=%b max=%0d vld=%b rdy=%b required %h %b %0d 1 0", c,
                 out_exp_offset, out_flush, out_max_exp, out_valid, in_ready, snap_o, snap_f, snap_m);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 1; k < 3; k++) begin
      pop(0, o, f, m, l, o2, f2, m2, l2);
      tests++;
      if ({o, f, m, l} !== {ref_off(q[k], mx, 4), ref_flush(q[k], mx, 4), EW'(mx), k == 2}) begin
        fails++;
        $display("FAIL backpressure_b%0d: off=%h fl=%b max=%0d last=%b required %h %b %0d %0b", k, o, f, m, l,
                 ref_off(q[k], mx, 4), ref_flush(q[k], mx, 4), mx, k == 2);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [W-1:0] o, o2;
    logic [L-1:0] f, f2;
    logic [EW-1:0] m, m2;
    logic l, l2;
    send(pk(7, 6, 7, 5), 0);
    send(pk(7, 7, 7, 7), 0);
    send(pk(3, 7, 2, 6), 1);
    pop(0, o, f, m, l, o2, f2, m2, l2);
    #2;
    rst_n = 0;
    #1;
    tests++;
    if ({out_valid, in_ready, out_max_exp} !== {1'b0, 1'b1, 3'd0}) begin
      fails++;
      $display("FAIL reset_mid_drain: vld=%b rdy=%b max=%0d required 0 1 0", out_valid, in_ready, out_max_exp);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    send(pk(1, 0, 2, 1), 1);
    pop(0, o, f, m, l, o2, f2, m2, l2);
    tests++;
    if ({o, f, m, l} !== {pk(1, 2, 0, 1), 4'b0000, 3'd2, 1'b1}) begin
      fails++;
      $display("FAIL reset_fresh_group: off=%h fl=%b max=%0d last=%b required %h 0000 2 1", o, f, m, l, pk(1, 2, 0, 1));
    end
  endtask

  task automatic test_default_max_shift();
    logic [W-1:0] o, o2;
    logic [L-1:0] f, f2;
    logic [EW-1:0] m, m2;
    logic l, l2;
    send(pk(0, 0, 0, 7), 1);
    pop(0, o, f, m, l, o2, f2, m2, l2);
    tests++;
    if ({o2, f2, m2, l2} !== {pk(7, 7, 7, 0), 4'b0000, 3'd7, 1'b1}) begin
      fails++;
      $display("FAIL default_max_shift: off=%h fl=%b max=%0d last=%b required %h 0000 7 1", o2, f2, m2, l2, pk(7, 7, 7, 0));
    end
    tests++;
    if ({o, f} !== {pk(4, 4, 4, 0), 4'b1110}) begin
      fails++;
      $display("FAIL clamp_max_shift4: off=%h fl=%b required %h 1110", o, f, pk(4, 4, 4, 0));
    end
  endtask

  task automatic test_random();
    logic [W-1:0] o, o2;
    logic [L-1:0] f, f2;
    logic [EW-1:0] m, m2;
    logic l, l2;
    for (int g = 0; g < 25; g++) begin
      logic [W-1:0] q[$];
      int n, mx;
      bit forced;
      n = $urandom_range(1, 4);
      forced = (n == 4) && $urandom_range(0, 1) == 1;
      for (int k = 0; k < n; k++) begin
        q.push_back(W'($urandom));
        send(q[k], (k == n - 1) && !forced);
      end
      mx = ref_max(q);
      for (int k = 0; k < n; k++) begin
        pop(1, o, f, m, l, o2, f2, m2, l2);
        tests++;
        if ({o, f, m, l, o2, f2, m2, l2} !== {ref_off(q[k], mx, 4), ref_flush(q[k], mx, 4), EW'(mx), k == n - 1,
                                              ref_off(q[k], mx, 7), ref_flush(q[k], mx, 7), EW'(mx), k == n - 1}) begin
          fails++;
          $display("FAIL random_g%0d_b%0d: off=%h fl=%b max=%0d last=%b off7=%h fl7=%b required %h %b %0d %0b %h %b",
                   g, k, o, f, m, l, o2, f2, ref_off(q[k], mx, 4), ref_flush(q[k], mx, 4), mx, k == n - 1,
                   ref_off(q[k], mx, 7), ref_flush(q[k], mx, 7));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_beat();
    test_single_beat();
    test_forced_close();
    test_backpressure();
    test_reset_mid_drain();
    test_default_max_shift();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/exp_block_normalizer.md
# exp_block_normalizer

Multi-beat block-floating-point exponent normalizer for the GEMM/FFT datapath. It buffers a group of up to `DEPTH` beats of `LANES` unsigned exponents and tracks the running group maximum. It then replays each buffered beat with per-lane right-shift offsets relative to the shared group maximum, clamped to the mantissa aligner's shift range. It replaces single-beat, 4-lane comparison-plus-offset logic wherever a shared exponent must span several consecutive input vectors.

## Interface
- `EXP_WIDTH`, 3 — exponent width per lane, unsigned.
- `LANES`, 4 — exponents per beat, ≥ 2.
- `DEPTH`, 4 — maximum beats per group, ≥ 1; buffer depth.
- `MAX_SHIFT`, 2**EXP_WIDTH-1 — offset saturation limit, ≤ 2**EXP_WIDTH-1.

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — reset, asynchronous and active-low.
- `in_valid` in 1 — input beat valid.
- `in_ready` out 1 — block accepts a beat this cycle.
- `in_exp` in EXP_WIDTH*LANES — lane i at `[i*EXP_WIDTH +: EXP_WIDTH]`, lane 0 in the LSBs.
- `in_last` in 1 — final beat of the group.
- `out_valid` out 1 — output beat valid.
- `out_ready` in 1 — downstream accepts the output beat.
- `out_exp_offset` out EXP_WIDTH*LANES — per-lane offset `min(group_max - exp_i, MAX_SHIFT)`, packed like `in_exp`.
- `out_flush` out LANES — bit i set when lane i offset was clamped (the lane shifts out entirely).
- `out_max_exp` out EXP_WIDTH — group maximum, constant for the whole group.
- `out_last` out 1 — last beat of the group.

## Operation
- There are two states, COLLECT and DRAIN. Reset enters COLLECT with beat count 0, running max 0, and buffer contents don't-care.
- **COLLECT:**
  - `in_ready`=1 and `out_valid`=0.
  - On `in_valid && in_ready`: write `in_exp` to `buf[count]`, set `run_max = max(run_max, max over lanes(in_exp))` (first beat of a group loads the value directly), and increment `count`.
  - Leave for DRAIN when the accepted beat has `in_last`=1, or when `count` reaches DEPTH (forced close; later input starts a new group).
  - On transition, latch `run_max` (including the current beat) into `grp_max` and latch `n = count`. Reset the read index to 0.
- **DRAIN:**
  - `in_ready`=0 and `out_valid`=1.
  - Outputs are computed combinationally from `buf[rd]` and `grp_max`. `out_last = (rd == n-1)`.
  - On `out_valid && out_ready`, increment `rd`. After the handshake with `out_last`=1, return to COLLECT and clear `count` and `run_max`.
- **Arithmetic:**
  - The subtraction `grp_max - exp_i` is always ≥ 0 and is computed in EXP_WIDTH bits, so there is no wrap.
  - A clamp applies iff the difference > MAX_SHIFT. `out_flush` bit i = clamp condition.
  - Ties between lanes have no effect, since only the maximum value is needed.
- **Backpressure:** output fields hold stable while `out_valid && !out_ready`.
- **Reset mid-operation:** `rst_n` low in any state immediately drops `out_valid` and returns to COLLECT with `count` 0. A partial group is discarded and never emitted.

## Timing
- Reset values:
  - `in_ready`=1.
  - `out_valid`=0, `out_last`=0.
  - `out_exp_offset`=0, `out_flush`=0, `out_max_exp`=0. These are registered-state driven; gate with state so they read 0 outside DRAIN.
- Accept-to-first-output: `out_valid` rises the cycle after the closing beat is accepted (1-cycle latency).
- Throughput: a group of n beats takes n input cycles plus at least n output cycles. There is no overlap between COLLECT and DRAIN.
- `in_ready` falls in the same cycle that `out_valid` rises. `in_ready` returns the cycle after the final output handshake.
- No combinational path from `out_ready` to `in_ready` or from `in_valid` to `out_valid`.

## Structure
- Package `exp_norm_pkg`:
  - State encoding: COLLECT=0, DRAIN=1.
  - Function `clog2` for count widths.
  - Lane-slice helper for packing and unpacking.
- Sub-module `exp_max_tree`: a combinational LANES-input unsigned max-reduction tree with parameters EXP_WIDTH and LANES. It is instantiated once on `in_exp`. Offset/clamp logic stays inline.

## Test plan
Config: EXP_WIDTH=3, LANES=4, DEPTH=4, MAX_SHIFT=4 unless stated. Lanes are listed lane3..lane0.

- **Two-beat group:** send {1,5,2,3} then {6,0,4,4} with last. Beat 0 must give max 6, offsets {4,1,4,3}, flush 1000. Beat 1 must give offsets {0,4,2,2}, flush 0100, `out_last`=1.
- **Single-beat group** {7,7,7,7} with last → one output with offsets 0, max 7, `out_last`=1, `in_ready`=1 on the following cycle.
- **Forced close:** four beats with no `in_last` → DRAIN entered after the 4th beat. The 4th output has `out_last`=1, and a fifth beat presented starts a new group.
- **Backpressure:** hold `out_ready`=0 for 5 cycles mid-DRAIN → outputs stable, `in_ready` stays 0, and no beat is lost or duplicated.
- **Reset mid-DRAIN:** after 1 of 3 beats is drained, pulse `rst_n` low asynchronously → `out_valid`=0 immediately and `in_ready`=1. A subsequent group's max is unaffected by stale data.
- **Default MAX_SHIFT=7:** {0,0,0,7} → offsets {7,7,7,0} and flush 0000.
